// File: rtl/clock_pkg.sv
// Shared types and limits for the HH:MM clock datapath.
// Holds the edit-FSM state encoding and the wrap-around increment helpers.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = HOUR_W'(23);
    localparam logic [MIN_W-1:0]  MAX_MIN  = MIN_W'(59);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        AL_HR   = 3'd3,
        AL_MIN  = 3'd4
    } state_t;

    // Fields wrap independently; a minute wrap never touches the hour.
    function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
        return (h >= MAX_HOUR) ? '0 : h + HOUR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
        return (m >= MAX_MIN) ? '0 : m + MIN_W'(1);
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detector with hold-to-repeat for a debounced button level.
// 'inc' pulses once on the press and then periodically while the button stays held.
module btn_repeat #(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    input  logic restart,
    output logic press,
    output logic inc
);

    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic             btn_q;
    logic             armed;
    logic             active;
    logic [CNT_W-1:0] hold_cnt;
    logic             repeat_hit;

    // 'armed' only rises once the level has been seen low, so a button held
    // through reset cannot masquerade as a fresh press.
    assign press      = btn & ~btn_q & armed;
    assign repeat_hit = active & btn & repeat_en & (hold_cnt == DELAY_C);
    assign inc        = press | repeat_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q    <= 1'b0;
            armed    <= 1'b0;
            active   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            btn_q <= btn;
            armed <= armed | ~btn;
            if (!btn) begin
                active   <= 1'b0;
                hold_cnt <= '0;
            end else if (restart) begin
                active   <= active | press;
                hold_cnt <= '0;
            end else if (press) begin
                active   <= 1'b1;
                hold_cnt <= CNT_W'(1);
            end else if (active) begin
                // After the first repeat, reload so the next hit lands REPEAT_RATE later.
                if (hold_cnt == DELAY_C) begin
                    hold_cnt <= RELOAD_C;
                end else begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Mode/edit sequencer: walks RUN -> SET_HR -> SET_MIN -> AL_HR -> AL_MIN on mode presses,
// edits clock and alarm time with the set button, and drives display mux and blink flags.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int TIMEOUT_SEC  = 30,
    parameter int BLINK_HALF   = 250
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_set,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] curr_hour,
    input  logic [MIN_W-1:0]  curr_min,
    output logic              load_time,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MIN_W-1:0]  load_min,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic              alarm_en,
    output logic [HOUR_W-1:0] disp_hour,
    output logic [MIN_W-1:0]  disp_min,
    output logic              blink_hour,
    output logic              blink_min,
    output logic [2:0]        mode
);

    localparam int TO_W = $clog2(TIMEOUT_SEC + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [TO_W-1:0] TIMEOUT_C  = TO_W'(TIMEOUT_SEC);
    localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_HALF - 1);

    state_t            state_q, state_d;
    logic              mode_q, mode_armed, mode_press;
    logic              set_press, set_inc;
    logic              edit_state, timeout_hit, field_inc, load_d;
    logic [TO_W-1:0]   timeout_cnt;
    logic [BL_W-1:0]   blink_cnt, blink_cnt_d;
    logic              blink_phase, blink_phase_d;
    logic [HOUR_W-1:0] edit_hour;
    logic [MIN_W-1:0]  edit_min;

    assign mode_press  = btn_mode & ~mode_q & mode_armed;
    assign edit_state  = (state_q != RUN);
    assign timeout_hit = edit_state && (timeout_cnt == TIMEOUT_C);
    // Mode wins over a simultaneous set; a timeout swallows both.
    assign field_inc   = set_inc & edit_state & ~mode_press & ~timeout_hit;

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_set_btn (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn_set),
        .repeat_en (edit_state),
        .restart   (mode_press),
        .press     (set_press),
        .inc       (set_inc)
    );

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        if (timeout_hit) begin
            state_d = RUN;
        end else if (mode_press) begin
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: begin
                    state_d = AL_HR;
                    load_d  = 1'b1;
                end
                AL_HR:   state_d = AL_MIN;
                AL_MIN:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Blink restarts in the visible phase whenever the state or the edited value changes.
    always_comb begin
        blink_cnt_d   = blink_cnt + BL_W'(1);
        blink_phase_d = blink_phase;
        if ((state_d != state_q) || field_inc) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            mode_q      <= 1'b0;
            mode_armed  <= 1'b0;
            load_time   <= 1'b0;
            edit_hour   <= '0;
            edit_min    <= '0;
            alarm_hour  <= '0;
            alarm_min   <= '0;
            alarm_en    <= 1'b0;
            timeout_cnt <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_hour  <= 1'b0;
            blink_min   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= btn_mode;
            mode_armed <= mode_armed | ~btn_mode;
            load_time  <= load_d;

            if (state_q == RUN && state_d == SET_HR) begin
                edit_hour <= curr_hour;
                edit_min  <= curr_min;
            end else if (field_inc) begin
                case (state_q)
                    SET_HR:  edit_hour  <= next_hour(edit_hour);
                    SET_MIN: edit_min   <= next_min(edit_min);
                    AL_HR:   alarm_hour <= next_hour(alarm_hour);
                    AL_MIN:  alarm_min  <= next_min(alarm_min);
                    default: ;
                endcase
            end

            if (state_q == RUN && set_press && !mode_press) begin
                alarm_en <= ~alarm_en;
            end

            if (state_d == RUN || mode_press || set_inc) begin
                timeout_cnt <= '0;
            end else if (tick_1hz && timeout_cnt != TIMEOUT_C) begin
                timeout_cnt <= timeout_cnt + TO_W'(1);
            end

            blink_cnt   <= blink_cnt_d;
            blink_phase <= blink_phase_d;
            blink_hour  <= blink_phase_d && (state_d == SET_HR || state_d == AL_HR);
            blink_min   <= blink_phase_d && (state_d == SET_MIN || state_d == AL_MIN);
        end
    end

    always_comb begin
        disp_hour = curr_hour;
        disp_min  = curr_min;
        case (state_q)
            SET_HR, SET_MIN: begin
                disp_hour = edit_hour;
                disp_min  = edit_min;
            end
            AL_HR, AL_MIN: begin
                disp_hour = alarm_hour;
                disp_min  = alarm_min;
            end
            default: ;
        endcase
    end

    assign load_hour = edit_hour;
    assign load_min  = edit_min;
    assign mode      = state_q;

endmodule
